// File: rtl/lighthouse_pulse_timer.sv
// Timestamps TS4231 envelope pulses per channel, classifies sync/sweep by width, and merges records into one FIFO.
// Optional glitch rejection of short pulses is enabled by defining GLITCH_FILTER_EN.
module lighthouse_pulse_timer #(
  parameter int NUM_SENSORS      = 8,
  parameter int TS_WIDTH         = 24,
  parameter int PW_WIDTH         = 16,
  parameter int SYNC_MIN_CYCLES  = 960,
  parameter int FIFO_DEPTH       = 16,
  parameter int MIN_PULSE_CYCLES = 16,
  localparam int SW = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SENSORS-1:0] env_i,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SW-1:0]          out_sensor,
  output logic                   out_sync,
  output logic [TS_WIDTH-1:0]    out_ts,
  output logic [PW_WIDTH-1:0]    out_width,
  output logic [LW-1:0]          fifo_level,
  output logic [NUM_SENSORS-1:0] overflow,
  input  logic [NUM_SENSORS-1:0] ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);

`ifdef GLITCH_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  typedef struct packed {
    logic [SW-1:0]       sensor;
    logic                sync;
    logic [TS_WIDTH-1:0] ts;
    logic [PW_WIDTH-1:0] width;
  } rec_t;

  typedef enum logic {S_IDLE, S_HIGH} ch_state_t;

  logic [TS_WIDTH-1:0]    r_cnt;
  logic [NUM_SENSORS-1:0] r_s1, r_s2, r_prev;
  logic [NUM_SENSORS-1:0] w_rise, w_fall;

  ch_state_t              r_state     [NUM_SENSORS];
  ch_state_t              w_state_nxt [NUM_SENSORS];
  logic [TS_WIDTH-1:0]    r_ts        [NUM_SENSORS];
  logic [PW_WIDTH-1:0]    r_width     [NUM_SENSORS];
  rec_t                   r_hold      [NUM_SENSORS];
  rec_t                   w_rec       [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] r_hold_vld, r_ovf;
  logic [NUM_SENSORS-1:0] w_done, w_keep, w_drop, w_gnt_oh;

  logic                   w_gnt_vld;
  logic [SW-1:0]          w_gnt_idx;
  logic [SW:0]            w_idx;
  logic [SW-1:0]          r_rr;

  rec_t                   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr, r_rd;
  logic [LW-1:0]          r_lvl;
  logic                   w_full, w_push, w_pop;
  rec_t                   w_head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + TS_WIDTH'(1);
    end
  end

  // Synchroniser resets high so a sensor already high at reset release is not seen as a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '1;
      r_s2   <= '1;
      r_prev <= '1;
    end else begin
      r_s1   <= env_i;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_rise = r_s2 & ~r_prev;
  assign w_fall = ~r_s2 & r_prev;

  always_comb begin
    w_done = '0;
    w_keep = '0;
    for (int i = 0; i < NUM_SENSORS; i++) begin
      w_state_nxt[i] = r_state[i];
      case (r_state[i])
        S_IDLE: if (w_rise[i]) w_state_nxt[i] = S_HIGH;
        S_HIGH: if (w_fall[i]) begin
          w_state_nxt[i] = S_IDLE;
          w_done[i]      = 1'b1;
        end
      endcase
      w_rec[i].sensor = SW'(i);
      w_rec[i].sync   = (r_width[i] >= PW_WIDTH'(SYNC_MIN_CYCLES));
      w_rec[i].ts     = r_ts[i];
      w_rec[i].width  = r_width[i];
      w_keep[i] = w_done[i] & (~FILTER_ON | (r_width[i] >= PW_WIDTH'(MIN_PULSE_CYCLES)));
    end
  end

  // A holding register being granted this cycle is free to take the new record.
  assign w_drop = w_keep & r_hold_vld & ~w_gnt_oh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_state[i] <= S_IDLE;
        r_ts[i]    <= '0;
        r_width[i] <= '0;
        r_hold[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SENSORS; i++) begin
        r_state[i] <= w_state_nxt[i];
        if (r_state[i] == S_IDLE && w_rise[i]) begin
          r_ts[i]    <= r_cnt;
          r_width[i] <= PW_WIDTH'(1);
        end else if (r_state[i] == S_HIGH && !w_fall[i] && r_width[i] != '1) begin
          r_width[i] <= r_width[i] + PW_WIDTH'(1);
        end
        if (w_keep[i] && !w_drop[i]) r_hold[i] <= w_rec[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld <= '0;
      r_ovf      <= '0;
    end else begin
      r_hold_vld <= (r_hold_vld & ~w_gnt_oh) | (w_keep & ~w_drop);
      r_ovf      <= (r_ovf & ~ovf_clr) | w_drop;
    end
  end

  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_oh  = '0;
    w_idx     = '0;
    if (!w_full) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        w_idx = {1'b0, r_rr} + (SW+1)'(k);
        if (w_idx >= (SW+1)'(NUM_SENSORS)) w_idx = w_idx - (SW+1)'(NUM_SENSORS);
        if (!w_gnt_vld && r_hold_vld[w_idx[SW-1:0]]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = w_idx[SW-1:0];
        end
      end
      if (w_gnt_vld) w_gnt_oh[w_gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr <= '0;
    end else if (w_gnt_vld) begin
      r_rr <= (w_gnt_idx == SW'(NUM_SENSORS - 1)) ? '0 : w_gnt_idx + SW'(1);
    end
  end

  assign w_full = (r_lvl == LW'(FIFO_DEPTH));
  assign w_push = w_gnt_vld;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= r_hold[w_gnt_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + LW'(1);
        2'b01:   r_lvl <= r_lvl - LW'(1);
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  assign w_head     = r_mem[r_rd];
  assign out_valid  = (r_lvl != '0);
  assign out_sensor = out_valid ? w_head.sensor : '0;
  assign out_sync   = out_valid ? w_head.sync   : 1'b0;
  assign out_ts     = out_valid ? w_head.ts     : '0;
  assign out_width  = out_valid ? w_head.width  : '0;
  assign fifo_level = r_lvl;
  assign overflow   = r_ovf;

endmodule
